// File: rtl/datapath_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined datapath.
package datapath_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL1  = 4'd6;
    localparam logic [3:0] OP_SHR1  = 4'd7;
    localparam logic [3:0] OP_ASR1  = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_ADC   = 4'd10;
    localparam logic [3:0] OP_SBB   = 4'd11;
    localparam logic [3:0] OP_INC   = 4'd12;
    localparam logic [3:0] OP_DEC   = 4'd13;
    localparam logic [3:0] OP_CMP   = 4'd14;
    localparam logic [3:0] OP_PASSA = 4'd15;

    // Bit positions inside the 4-bit flag register, ordered {Z, N, C, V}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/dp_alu_p.sv
// Combinational ALU: one shared adder serves every arithmetic opcode,
// subtraction is done as A + ~B + carry so carry-out is the not-borrow.
module dp_alu_p
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             vout
);

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_k;
    logic [WIDTH:0]   sum;
    logic             is_arith;

    // Operand selection for the shared adder, then result/flag mux.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        add_x    = a;
        add_y    = b;
        add_k    = 1'b0;
        is_arith = 1'b0;
        f        = '0;
        cout     = 1'b0;
        vout     = 1'b0;

        unique case (op)
            OP_ADD:         begin is_arith = 1'b1; end
            OP_SUB, OP_CMP: begin is_arith = 1'b1; add_y = ~b; add_k = 1'b1; end
            OP_ADC:         begin is_arith = 1'b1; add_k = cin; end
            OP_SBB:         begin is_arith = 1'b1; add_y = ~b; add_k = cin; end
            OP_INC:         begin is_arith = 1'b1; add_y = WIDTH'(1); end
            OP_DEC:         begin is_arith = 1'b1; add_y = ~WIDTH'(1); add_k = 1'b1; end
            default:        ;
        endcase

        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_k};

        if (is_arith) begin
            f    = sum[WIDTH-1:0];
            cout = sum[WIDTH];
            // Overflow: both adder inputs share a sign that the sum does not.
            vout = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
        end else begin
            unique case (op)
                OP_AND:   f = a & b;
                OP_OR:    f = a | b;
                OP_XOR:   f = a ^ b;
                OP_NOT:   f = ~a;
                OP_SHL1:  begin f = {a[WIDTH-2:0], 1'b0}; cout = a[WIDTH-1]; end
                OP_SHR1:  begin f = {1'b0, a[WIDTH-1:1]}; cout = a[0]; end
                OP_ASR1:  begin f = {a[WIDTH-1], a[WIDTH-1:1]}; cout = a[0]; end
                OP_PASSB: f = b;
                OP_PASSA: f = a;
                default:  f = '0;
            endcase
        end
    end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath: stage R reads and forwards operands,
// stage X executes, writes back and updates the {Z,N,C,V} flag register.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    // Derived from NREGS; not meant to be overridden.
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             load_en,
    input  logic [AW-1:0]    a_sel,
    input  logic [AW-1:0]    b_sel,
    input  logic [AW-1:0]    dest_sel,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] const_in,
    input  logic             const_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_sel,
    input  logic             flag_en,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] result,
    output logic             res_valid,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] regs [NREGS];

    // X-stage latches; a_out/b_out are the latched operands themselves.
    logic             x_valid;
    logic             x_load;
    logic             x_dsel;
    logic             x_flag_en;
    logic [3:0]       x_op;
    logic [AW-1:0]    x_dest;
    logic [WIDTH-1:0] x_data;
    logic [3:0]       flags;

    logic [WIDTH-1:0] alu_f;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] d_val;
    logic             wb_en;
    logic [WIDTH-1:0] a_rd;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] b_rd;

    dp_alu_p #(.WIDTH(WIDTH)) u_alu (
        .op   (x_op),
        .a    (a_out),
        .b    (b_out),
        .cin  (flags[FLAG_C]),
        .f    (alu_f),
        .cout (alu_c),
        .vout (alu_v)
    );

    // Writeback value and enable; CMP only ever touches the flags.
    assign d_val = x_dsel ? x_data : alu_f;
    assign wb_en = x_valid && x_load && (x_op != OP_CMP);

    // Stage R operand read with forwarding of the in-flight X writeback.
    assign a_rd  = (wb_en && (x_dest == a_sel)) ? d_val : regs[a_sel];
    assign b_src = (wb_en && (x_dest == b_sel)) ? d_val : regs[b_sel];
    assign b_rd  = const_sel ? const_in : b_src;

    // Register file write at the end of X.
    // NOTE: the register file is cleared on reset, so it must live in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[x_dest] <= d_val;
        end
    end

    // R -> X pipeline latches; a bubble clears valid and holds the rest.
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid   <= 1'b0;
            x_load    <= 1'b0;
            x_dsel    <= 1'b0;
            x_flag_en <= 1'b0;
            x_op      <= '0;
            x_dest    <= '0;
            x_data    <= '0;
            a_out     <= '0;
            b_out     <= '0;
        end else begin
            x_valid <= in_valid;
            if (in_valid) begin
                x_load    <= load_en;
                x_dsel    <= data_sel;
                x_flag_en <= flag_en;
                x_op      <= op_sel;
                x_dest    <= dest_sel;
                x_data    <= data_in;
                a_out     <= a_rd;
                b_out     <= b_rd;
            end
        end
    end

    // Result, result-valid and flag register updated as X retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            res_valid <= 1'b0;
            flags     <= '0;
        end else begin
            res_valid <= x_valid;
            if (x_valid) result <= d_val;
            if (x_valid && x_flag_en) begin
                flags[FLAG_Z] <= (alu_f == '0);
                flags[FLAG_N] <= alu_f[WIDTH-1];
                flags[FLAG_C] <= alu_c;
                flags[FLAG_V] <= alu_v;
            end
        end
    end

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe with a result/flag scoreboard.
module tb_datapath_pipe;
    import datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, load_en, const_sel, data_sel, flag_en;
    logic [3:0]  a_sel, b_sel, dest_sel, op_sel;
    logic [15:0] const_in, data_in;
    logic [15:0] a_out, b_out, result;
    logic        res_valid, z, n, c, v;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  cur_flg;
    int          n_cmp = 0;
    int          n_fail = 0;

    datapath_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .load_en(load_en),
        .a_sel(a_sel), .b_sel(b_sel), .dest_sel(dest_sel), .op_sel(op_sel),
        .const_in(const_in), .const_sel(const_sel), .data_in(data_in),
        .data_sel(data_sel), .flag_en(flag_en), .a_out(a_out), .b_out(b_out),
        .result(result), .res_valid(res_valid), .z(z), .n(n), .c(c), .v(v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then retire any result the DUT presents.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.res));
                check("sb_flags", 32'({z, n, c, v}), 32'(e.flg));
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] dest, input logic load, input logic csel,
                         input logic [15:0] cval, input logic dsel, input logic [15:0] dval,
                         input logic fen, input logic [15:0] eres, input logic [3:0] eflg,
                         input bit push);
        exp_t e;
        in_valid  = 1'b1;
        op_sel    = op;
        a_sel     = a;
        b_sel     = b;
        dest_sel  = dest;
        load_en   = load;
        const_sel = csel;
        const_in  = cval;
        data_sel  = dsel;
        data_in   = dval;
        flag_en   = fen;
        if (fen) cur_flg = eflg;
        e.res = eres;
        e.flg = cur_flg;
        if (push) sb.push_back(e);
        tick();
    endtask

    task automatic load_const(input logic [3:0] dest, input logic [15:0] val);
        issue(OP_PASSB, 4'd0, 4'd0, dest, 1'b1, 1'b1, val, 1'b0, 16'h0, 1'b0, val, 4'h0, 1'b1);
    endtask

    task automatic read_reg(input logic [3:0] r, input logic [15:0] exp);
        issue(OP_PASSA, r, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, exp, 4'h0, 1'b1);
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        cur_flg = 4'h0;
        rst = 1'b1; in_valid = 1'b0; load_en = 1'b0; const_sel = 1'b0; data_sel = 1'b0;
        flag_en = 1'b0; a_sel = '0; b_sel = '0; dest_sel = '0; op_sel = '0;
        const_in = '0; data_in = '0;
        tick();
        tick();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({z, n, c, v}), 32'd0);
        check("rst_a_out", 32'(a_out), 32'd0);
        rst = 1'b0;

        // Dependency chain through forwarding: r1 = 0x7FFF, r2 = r1 + 1.
        issue(OP_PASSB, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'h7FFF, 1'b0, 16'h0, 1'b1, 16'h7FFF, 4'b0000, 1'b1);
        issue(OP_ADD,   4'd1, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b1, 16'h8000, 4'b0101, 1'b1);
        check("fwd_a_out", 32'(a_out), 32'h7FFF);
        check("const_b_out", 32'(b_out), 32'h0001);
        read_reg(4'd2, 16'h8000);
        check("fwd_r2_a_out", 32'(a_out), 32'h8000);
        read_reg(4'd1, 16'h7FFF);

        // Carry chain: 0xFFFF + 1 then ADC 0 + 0 consumes the carry.
        load_const(4'd7, 16'hFFFF);
        issue(OP_ADD, 4'd7, 4'd0, 4'd8, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b1, 16'h0000, 4'b1010, 1'b1);
        issue(OP_ADC, 4'd8, 4'd0, 4'd9, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b1, 16'h0001, 4'b0000, 1'b1);
        read_reg(4'd9, 16'h0001);

        // Compare never writes back.
        load_const(4'd3, 16'h0005);
        issue(OP_CMP, 4'd3, 4'd0, 4'd10, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0, 1'b1, 16'h0000, 4'b1010, 1'b1);
        issue(OP_CMP, 4'd3, 4'd0, 4'd10, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0, 1'b1, 16'hFFFF, 4'b0100, 1'b1);
        read_reg(4'd3, 16'h0005);
        read_reg(4'd10, 16'h0000);

        // flag_en = 0 leaves flags alone; bubbles hold result and drop res_valid.
        issue(OP_ADD, 4'd3, 4'd0, 4'd11, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, 16'h0006, 4'h0, 1'b1);
        bubble();
        bubble();
        check("bubble_res_valid", 32'(res_valid), 32'd0);
        check("bubble_result_held", 32'(result), 32'h0006);
        check("bubble_flags", 32'({z, n, c, v}), 32'b0100);
        read_reg(4'd11, 16'h0006);

        // data_sel writes external data while flags follow the ALU (PASS B of 0).
        issue(OP_PASSB, 4'd0, 4'd0, 4'd12, 1'b1, 1'b1, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 16'hA5A5, 4'b1000, 1'b1);
        load_const(4'd13, 16'h8001);
        issue(OP_ASR1, 4'd13, 4'd0, 4'd14, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'hC000, 4'b0110, 1'b1);
        issue(OP_SHR1, 4'd13, 4'd0, 4'd15, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h4000, 4'b0010, 1'b1);
        read_reg(4'd12, 16'hA5A5);
        read_reg(4'd14, 16'hC000);

        // Reset mid-stream: the instruction sitting in X is discarded.
        issue(OP_PASSB, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b1, 16'h1234, 4'b0000, 1'b1);
        issue(OP_PASSB, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 16'h9999, 1'b0, 16'h0, 1'b0, 16'h9999, 4'h0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_flags", 32'({z, n, c, v}), 32'd0);
        rst = 1'b0;
        cur_flg = 4'h0;
        for (int r = 0; r < 16; r++) read_reg(4'(r), 16'h0000);

        // Drain with a bounded number of idle cycles.
        for (int i = 0; i < 4 && sb.size() != 0; i++) bubble();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised two-stage successor of the single-cycle register-file/ALU datapath.
- Stage R reads the register file and muxes in the constant; stage X executes, writes back and updates a registered 4-bit flag set (Z, N, C, V).
- Adds single-level forwarding from X to R, carry-chained ops, compare-without-writeback, and a valid-qualified result output.
- Sits between the controller/sequencer and the data bus.

Parameters:
- WIDTH, 16, datapath and register width (>= 4).
- NREGS, 16, number of general registers (power of two, >= 2).
- AW, $clog2(NREGS), register select width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction present in stage R this cycle
- load_en  in  1  write result to dest_sel
- a_sel  in  AW  A operand register
- b_sel  in  AW  B operand register
- dest_sel  in  AW  destination register
- op_sel  in  4  operation code
- const_in  in  WIDTH  immediate operand
- const_sel  in  1  1: B operand = const_in
- data_in  in  WIDTH  external write data
- data_sel  in  1  1: write back data_in instead of ALU result
- flag_en  in  1  update flags from this instruction
- a_out  out  WIDTH  registered A operand in X (after forwarding)
- b_out  out  WIDTH  registered B operand in X (after const mux)
- result  out  WIDTH  registered writeback value
- res_valid  out  1  result holds a newly executed instruction
- z, n, c, v  out  1 each  registered flags

Behaviour:
- Reset (synchronous, wins over everything):
  - Clears all NREGS registers, X-stage valid and all X latches, a_out, b_out, result, res_valid and all flags.
  - An instruction in X at reset is discarded with no writeback.
- Stage R, cycle N:
  - Read A = reg[a_sel] and Bsrc = reg[b_sel].
  - Forwarding: if X is valid and its writeback is enabled and dest matches a_sel (resp. b_sel), that operand takes the X writeback value D combinationally.
  - B = const_sel ? const_in : Bsrc.
  - If in_valid, latch A, B, op, dest, load_en, data_sel, data_in and flag_en into X. Otherwise X valid = 0 and the latches hold.
- Stage X, cycle N+1:
  - F = ALU(op, A, B, c).
  - D = data_sel ? data_in_latched : F.
  - Writeback enable = valid & load_en & (op != CMP).
  - At the end of N+1: register write, result <= D, res_valid <= valid, and flags update if valid & flag_en.
- Latency:
  - Register and flags updated at the edge ending N+1; result/res_valid visible in cycle N+2.
  - A back-to-back dependent instruction sees the new value via forwarding with no stall.
  - ADC/SBB in X read the flag register, which is already updated by the previous instruction.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL1 A, 7 SHR1 A (logical), 8 ASR1 A, 9 PASS B.
  - 10 ADC (A+B+c), 11 SBB (A-B-~c, c = not-borrow), 12 INC A, 13 DEC A, 14 CMP (SUB, never writes back), 15 PASS A.
- Flags (from F, independent of data_sel):
  - Z = (F == 0); N = F[WIDTH-1].
  - Arithmetic ops: C = carry-out, with subtract carry = not-borrow; V = two's-complement overflow.
  - SHL1: C = A[WIDTH-1]. SHR1/ASR1: C = A[0]; V = 0.
  - Logical and PASS ops: C = 0, V = 0.
- Width rules: results truncate to WIDTH bits; wrap-around is silent except for C/V.
- Simultaneous write and read of the same register from two instructions resolves by forwarding, never by a stale read.
- in_valid = 0 inserts a bubble: no writeback and no flag change; result holds its value and res_valid = 0.

Decomposition:
- Package datapath_pkg: opcode localparams OP_ADD..OP_PASSA, and flag bit indices.
- One sub-module dp_alu_p (parametrised WIDTH, combinational): inputs op, a, b, cin; outputs f, cout, vout.
- Register file, forwarding and pipeline registers stay in datapath_pipe.

Test Plan:
- Reset: after writes, rst for 1 cycle → all regs read 0, flags 0, res_valid 0 on the next cycle; an instruction in X during rst is never written.
- Dependency chain: r1 = const 0x7FFF (PASS B), next cycle r2 = r1 ADD const 1 → result 0x8000 with res_valid; N=1, V=1, C=0, Z=0; r2 = 0x8000 via forwarding.
- Carry chain: ADD 0xFFFF+0x0001 → result 0, Z=1, C=1; immediately ADC 0x0000+0x0000 → 0x0001, C=0.
- CMP: r3 = 5, CMP r3 vs const 5 → Z=1, C=1, r3 and dest unchanged; CMP 5 vs 6 → N=1, C=0.
- Bubble and flag_en: ADD with flag_en=0 → flags unchanged; in_valid=0 cycle → no reg change, res_valid=0, result held.
- data_sel and shifts: data_in = 0xA5A5 with data_sel=1 → reg = 0xA5A5, flags from F; ASR1 0x8001 → 0xC000, C=1.
